// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode and select encodings for the multi-cycle controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINKWB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_SLL   = 3'b110;

    // ALUOp is the controller's coarse request; alu_decoder refines FUNCT via funct fields.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_B = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    function automatic logic [2:0] immSrcFor(input logic [6:0] op);
        logic [2:0] imm;
        imm = IMM_I;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_LUI:    imm = IMM_U;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the controller's ALUOp plus funct fields onto the 3-bit ALUControl code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] i_aluOp,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7,
    input  logic       i_op5,
    output logic [2:0] o_aluControl
);

    always_comb begin
        o_aluControl = ALU_ADD;
        case (i_aluOp)
            ALUOP_SUB:   o_aluControl = ALU_SUB;
            ALUOP_PASSB: o_aluControl = ALU_PASSB;
            ALUOP_FUNCT: begin
                // funct7 only selects sub for register forms; addi with IR[30] set stays add
                case (i_funct3)
                    3'b000:  o_aluControl = (i_funct7 && i_op5) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_aluControl = ALU_SLL;
                    3'b010:  o_aluControl = ALU_SLT;
                    3'b110:  o_aluControl = ALU_OR;
                    3'b111:  o_aluControl = ALU_AND;
                    default: o_aluControl = ALU_ADD;
                endcase
            end
            default:     o_aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing a shared-ALU, shared-memory RV32I-subset datapath.
// Define BUS_WAIT_EN to add mem_ready_i, which stalls FETCH, MEMREAD and MEMWRITE while low.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_i,
    input  logic       Zero_i,
`ifdef BUS_WAIT_EN
    input  logic       mem_ready_i,
`endif
    output logic       PCWrite_o,
    output logic       IRWrite_o,
    output logic       AdrSrc_o,
    output logic       MemWrite_o,
    output logic       RegWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ImmSrc_o,
    output logic [2:0] ALUControl_o,
    output logic       instr_done_o,
    output logic       trap_o
);

    state_t     r_state;
    state_t     w_nextState;
    logic [1:0] w_aluOp;
    logic       w_memReady;

`ifdef BUS_WAIT_EN
    assign w_memReady = mem_ready_i;
`else
    assign w_memReady = 1'b1;
`endif

    alu_decoder u_aluDecoder (
        .i_aluOp      (w_aluOp),
        .i_funct3     (funct3_i),
        .i_funct7     (funct7_i),
        .i_op5        (op_i[5]),
        .o_aluControl (ALUControl_o)
    );

    assign ImmSrc_o = immSrcFor(op_i);
    assign trap_o   = (r_state == S_TRAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_aluOp      = ALUOP_ADD;
        PCWrite_o    = 1'b0;
        IRWrite_o    = 1'b0;
        AdrSrc_o     = 1'b0;
        MemWrite_o   = 1'b0;
        RegWrite_o   = 1'b0;
        ResultSrc_o  = RES_ALUOUT;
        ALUSrcA_o    = SRCA_PC;
        ALUSrcB_o    = SRCB_RS2;
        instr_done_o = 1'b0;

        case (r_state)
            S_FETCH: begin
                IRWrite_o   = w_memReady;
                PCWrite_o   = w_memReady;
                ALUSrcB_o   = SRCB_FOUR;
                ResultSrc_o = RES_ALURESULT;
                w_nextState = w_memReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // precompute the branch target into ALUOut while the opcode is decoded
                ALUSrcA_o = SRCA_OLDPC;
                ALUSrcB_o = SRCB_IMM;
                case (op_i)
                    OP_LOAD, OP_STORE: w_nextState = S_MEMADR;
                    OP_RTYPE:          w_nextState = S_EXECR;
                    OP_IARITH:         w_nextState = S_EXECI;
                    OP_BRANCH:         w_nextState = S_BRANCH;
                    OP_JAL:            w_nextState = S_JAL;
                    OP_JALR:           w_nextState = S_JALR;
                    OP_LUI:            w_nextState = S_LUI;
                    default:           w_nextState = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA_o   = SRCA_RS1;
                ALUSrcB_o   = SRCB_IMM;
                w_nextState = op_i[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc_o    = 1'b1;
                w_nextState = w_memReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc_o  = RES_READDATA;
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
                w_nextState  = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc_o     = 1'b1;
                MemWrite_o   = 1'b1;
                instr_done_o = w_memReady;
                w_nextState  = w_memReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA_o   = SRCA_RS1;
                ALUSrcB_o   = SRCB_RS2;
                w_aluOp     = ALUOP_FUNCT;
                w_nextState = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA_o   = SRCA_RS1;
                ALUSrcB_o   = SRCB_IMM;
                w_aluOp     = ALUOP_FUNCT;
                w_nextState = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcB_o   = SRCB_IMM;
                w_aluOp     = ALUOP_PASSB;
                w_nextState = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc_o  = RES_ALUOUT;
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
                w_nextState  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o    = SRCA_RS1;
                ALUSrcB_o    = SRCB_RS2;
                w_aluOp      = ALUOP_SUB;
                ResultSrc_o  = RES_ALUOUT;
                PCWrite_o    = ((funct3_i == 3'b000) && Zero_i) ||
                               ((funct3_i == 3'b001) && !Zero_i);
                instr_done_o = 1'b1;
                w_nextState  = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA_o   = SRCA_OLDPC;
                ALUSrcB_o   = SRCB_IMM;
                ResultSrc_o = RES_ALURESULT;
                PCWrite_o   = 1'b1;
                w_nextState = S_LINKWB;
            end
            S_JALR: begin
                ALUSrcA_o   = SRCA_RS1;
                ALUSrcB_o   = SRCB_IMM;
                ResultSrc_o = RES_ALURESULT;
                PCWrite_o   = 1'b1;
                w_nextState = S_LINKWB;
            end
            S_LINKWB: begin
                // link value is OldPC + 4, recomputed since ALUOut holds the jump target
                ALUSrcA_o    = SRCA_OLDPC;
                ALUSrcB_o    = SRCB_FOUR;
                ResultSrc_o  = RES_ALURESULT;
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
                w_nextState  = S_FETCH;
            end
            S_TRAP: begin
                w_nextState = S_TRAP;
            end
            default: begin
                w_nextState = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven per-cycle check of the controller outputs,
// plus hand sequences for trap, mid-instruction reset and (with BUS_WAIT_EN) memory stalls.
module tb_multicycle_controller;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  funct3;
        logic        funct7;
        logic        zero;
        logic [18:0] expected;
        string       name;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero;
    logic       memReady;
    logic       pcWrite;
    logic       irWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] immSrc;
    logic [2:0] aluControl;
    logic       instrDone;
    logic       trap;

    int   nCompared;
    int   nMismatched;
    vec_t vecs[$];

    logic [6:0]  curOp;
    logic [2:0]  curFunct3;
    logic        curFunct7;
    logic        curZero;
    string       curName;

    multicycle_controller dut (
        .clk          (clk),
        .rst          (rst),
        .op_i         (op),
        .funct3_i     (funct3),
        .funct7_i     (funct7),
        .Zero_i       (zero),
`ifdef BUS_WAIT_EN
        .mem_ready_i  (memReady),
`endif
        .PCWrite_o    (pcWrite),
        .IRWrite_o    (irWrite),
        .AdrSrc_o     (adrSrc),
        .MemWrite_o   (memWrite),
        .RegWrite_o   (regWrite),
        .ResultSrc_o  (resultSrc),
        .ALUSrcA_o    (aluSrcA),
        .ALUSrcB_o    (aluSrcB),
        .ImmSrc_o     (immSrc),
        .ALUControl_o (aluControl),
        .instr_done_o (instrDone),
        .trap_o       (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed order: PCWrite IRWrite AdrSrc MemWrite RegWrite ResultSrc SrcA SrcB ImmSrc ALUControl done trap
    function automatic logic [18:0] mk(input logic pcw, input logic irw, input logic adr,
                                       input logic mw, input logic rw, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] imm, input logic [2:0] alu,
                                       input logic done, input logic tr);
        return {pcw, irw, adr, mw, rw, res, a, b, imm, alu, done, tr};
    endfunction

    function automatic logic [18:0] eFetch(input logic [2:0] imm);
        return mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
    endfunction

    function automatic logic [18:0] eDecode(input logic [2:0] imm);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0);
    endfunction

    function automatic logic [18:0] eAluWb(input logic [2:0] imm);
        return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0);
    endfunction

    task automatic beginInstr(input string n, input logic [6:0] o, input logic [2:0] f3,
                              input logic f7, input logic z);
        curName   = n;
        curOp     = o;
        curFunct3 = f3;
        curFunct7 = f7;
        curZero   = z;
    endtask

    task automatic addRow(input string stateName, input logic [18:0] e);
        vec_t v;
        v.op       = curOp;
        v.funct3   = curFunct3;
        v.funct7   = curFunct7;
        v.zero     = curZero;
        v.expected = e;
        v.name     = {curName, ".", stateName};
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z);
        op     = o;
        funct3 = f3;
        funct7 = f7;
        zero   = z;
    endtask

    task automatic checkOutput(input string n, input logic [18:0] e);
        logic [18:0] actual;
        actual = {pcWrite, irWrite, adrSrc, memWrite, regWrite, resultSrc, aluSrcA,
                  aluSrcB, immSrc, aluControl, instrDone, trap};
        nCompared++;
        if (actual !== e) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", n, actual, e);
        end
    endtask

    task automatic runRow(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic z, input string n, input logic [18:0] e);
        applyStimulus(o, f3, f7, z);
        #1;
        checkOutput(n, e);
        @(negedge clk);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        memReady    = 1'b1;

        beginInstr("add", 7'b0110011, 3'b000, 1'b0, 1'b0);
        addRow("F", eFetch(3'b000)); addRow("D", eDecode(3'b000));
        addRow("EXECR", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0));
        addRow("ALUWB", eAluWb(3'b000));

        beginInstr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0);
        addRow("F", eFetch(3'b000)); addRow("D", eDecode(3'b000));
        addRow("EXECR", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0, 0));
        addRow("ALUWB", eAluWb(3'b000));

        beginInstr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0);
        addRow("F", eFetch(3'b000)); addRow("D", eDecode(3'b000));
        addRow("EXECI", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
        addRow("ALUWB", eAluWb(3'b000));

        beginInstr("slti", 7'b0010011, 3'b010, 1'b0, 1'b0);
        addRow("F", eFetch(3'b000)); addRow("D", eDecode(3'b000));
        addRow("EXECI", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b101, 0, 0));
        addRow("ALUWB", eAluWb(3'b000));

        beginInstr("ori", 7'b0010011, 3'b110, 1'b0, 1'b0);
        addRow("F", eFetch(3'b000)); addRow("D", eDecode(3'b000));
        addRow("EXECI", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b011, 0, 0));
        addRow("ALUWB", eAluWb(3'b000));

        beginInstr("and", 7'b0110011, 3'b111, 1'b0, 1'b0);
        addRow("F", eFetch(3'b000)); addRow("D", eDecode(3'b000));
        addRow("EXECR", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b010, 0, 0));
        addRow("ALUWB", eAluWb(3'b000));

        beginInstr("sll", 7'b0110011, 3'b001, 1'b0, 1'b0);
        addRow("F", eFetch(3'b000)); addRow("D", eDecode(3'b000));
        addRow("EXECR", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b110, 0, 0));
        addRow("ALUWB", eAluWb(3'b000));

        beginInstr("xor_f7", 7'b0110011, 3'b100, 1'b1, 1'b0);
        addRow("F", eFetch(3'b000)); addRow("D", eDecode(3'b000));
        addRow("EXECR", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0));
        addRow("ALUWB", eAluWb(3'b000));

        beginInstr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0);
        addRow("F", eFetch(3'b000)); addRow("D", eDecode(3'b000));
        addRow("MEMADR", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
        addRow("MEMREAD", mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
        addRow("MEMWB", mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));

        beginInstr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0);
        addRow("F", eFetch(3'b010)); addRow("D", eDecode(3'b010));
        addRow("MEMADR", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 0, 0));
        addRow("MEMWRITE", mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b010, 3'b000, 1, 0));

        beginInstr("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1);
        addRow("F", eFetch(3'b001)); addRow("D", eDecode(3'b001));
        addRow("BRANCH", mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b001, 1, 0));

        beginInstr("bne_z1", 7'b1100011, 3'b001, 1'b0, 1'b1);
        addRow("F", eFetch(3'b001)); addRow("D", eDecode(3'b001));
        addRow("BRANCH", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b001, 1, 0));

        beginInstr("bne_z0", 7'b1100011, 3'b001, 1'b0, 1'b0);
        addRow("F", eFetch(3'b001)); addRow("D", eDecode(3'b001));
        addRow("BRANCH", mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b001, 1, 0));

        beginInstr("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0);
        addRow("F", eFetch(3'b001)); addRow("D", eDecode(3'b001));
        addRow("BRANCH", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b001, 1, 0));

        beginInstr("blt_z1", 7'b1100011, 3'b100, 1'b0, 1'b1);
        addRow("F", eFetch(3'b001)); addRow("D", eDecode(3'b001));
        addRow("BRANCH", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b001, 1, 0));

        beginInstr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0);
        addRow("F", eFetch(3'b100)); addRow("D", eDecode(3'b100));
        addRow("JAL", mk(1, 0, 0, 0, 0, 2'b10, 2'b01, 2'b01, 3'b100, 3'b000, 0, 0));
        addRow("LINKWB", mk(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b100, 3'b000, 1, 0));

        beginInstr("jalr", 7'b1100111, 3'b000, 1'b0, 1'b0);
        addRow("F", eFetch(3'b000)); addRow("D", eDecode(3'b000));
        addRow("JALR", mk(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
        addRow("LINKWB", mk(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000, 1, 0));

        beginInstr("lui", 7'b0110111, 3'b000, 1'b0, 1'b0);
        addRow("F", eFetch(3'b011)); addRow("D", eDecode(3'b011));
        addRow("LUI", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b011, 3'b100, 0, 0));
        addRow("ALUWB", eAluWb(3'b011));

        beginInstr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0);
        addRow("F", eFetch(3'b000)); addRow("D", eDecode(3'b000));

        // Reset state: outputs show FETCH decode while rst is held.
        rst = 1'b1;
        applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0);
        #2;
        checkOutput("reset.FETCH", eFetch(3'b000));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            runRow(vecs[i].op, vecs[i].funct3, vecs[i].funct7, vecs[i].zero,
                   vecs[i].name, vecs[i].expected);
        end

        // Illegal opcode parks in TRAP with every enable low until reset.
        for (int i = 0; i < 20; i++) begin
            runRow(7'b1111111, 3'b000, 1'b0, 1'b0, $sformatf("trap.cycle%0d", i),
                   mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1));
        end
        rst = 1'b1;
        #1;
        checkOutput("trap.reset", eFetch(3'b000));
        @(negedge clk);
        rst = 1'b0;

        // Reset asynchronously in the middle of MEMWRITE: MemWrite must drop at once.
        runRow(7'b0100011, 3'b010, 1'b0, 1'b0, "swrst.F", eFetch(3'b010));
        runRow(7'b0100011, 3'b010, 1'b0, 1'b0, "swrst.D", eDecode(3'b010));
        runRow(7'b0100011, 3'b010, 1'b0, 1'b0, "swrst.MEMADR",
               mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 0, 0));
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
        #1;
        checkOutput("swrst.MEMWRITE", mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b010, 3'b000, 1, 0));
        rst = 1'b1;
        #1;
        checkOutput("swrst.afterRst", eFetch(3'b010));
        @(negedge clk);
        rst = 1'b0;

`ifdef BUS_WAIT_EN
        // add with a three-cycle fetch stall takes 7 cycles in total.
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            runRow(7'b0110011, 3'b000, 1'b0, 1'b0, $sformatf("wait.F%0d", i),
                   mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));
        end
        memReady = 1'b1;
        runRow(7'b0110011, 3'b000, 1'b0, 1'b0, "wait.Fready", eFetch(3'b000));
        runRow(7'b0110011, 3'b000, 1'b0, 1'b0, "wait.D", eDecode(3'b000));
        runRow(7'b0110011, 3'b000, 1'b0, 1'b0, "wait.EXECR",
               mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0));
        runRow(7'b0110011, 3'b000, 1'b0, 1'b0, "wait.ALUWB", eAluWb(3'b000));

        // Store held in MEMWRITE keeps MemWrite high; done only once ready.
        runRow(7'b0100011, 3'b010, 1'b0, 1'b0, "wsw.F", eFetch(3'b010));
        runRow(7'b0100011, 3'b010, 1'b0, 1'b0, "wsw.D", eDecode(3'b010));
        runRow(7'b0100011, 3'b010, 1'b0, 1'b0, "wsw.MEMADR",
               mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 0, 0));
        memReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            runRow(7'b0100011, 3'b010, 1'b0, 1'b0, $sformatf("wsw.hold%0d", i),
                   mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b010, 3'b000, 0, 0));
        end
        memReady = 1'b1;
        runRow(7'b0100011, 3'b010, 1'b0, 1'b0, "wsw.MEMWRITE",
               mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b010, 3'b000, 1, 0));

        // Load held in MEMREAD for one cycle, then writes back.
        runRow(7'b0000011, 3'b010, 1'b0, 1'b0, "wlw.F", eFetch(3'b000));
        runRow(7'b0000011, 3'b010, 1'b0, 1'b0, "wlw.D", eDecode(3'b000));
        runRow(7'b0000011, 3'b010, 1'b0, 1'b0, "wlw.MEMADR",
               mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
        memReady = 1'b0;
        runRow(7'b0000011, 3'b010, 1'b0, 1'b0, "wlw.hold",
               mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
        memReady = 1'b1;
        runRow(7'b0000011, 3'b010, 1'b0, 1'b0, "wlw.MEMREAD",
               mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
        runRow(7'b0000011, 3'b010, 1'b0, 1'b0, "wlw.MEMWB",
               mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencing controller for the RV32I-subset core: a state machine that replaces the single-cycle main decoder and drives a shared-ALU, shared-memory datapath over several cycles per instruction. It sits beside the instruction register (IR), consumes opcode/funct fields and the ALU zero flag, and emits per-cycle mux selects and write enables for PC, IR, register file, memory and ALU. It supports R-type, I-arith, load, store, BEQ/BNE, JAL, JALR and LUI.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- op_i  in  7  IR[6:0]
- funct3_i  in  3  IR[14:12]
- funct7_i  in  1  IR[30]
- Zero_i  in  1  ALU zero flag, current cycle
- mem_ready_i  in  1  memory ready; present only with BUS_WAIT_EN
- PCWrite_o  out  1  PC register load
- IRWrite_o  out  1  IR and OldPC load
- AdrSrc_o  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite_o  out  1  data memory write
- RegWrite_o  out  1  register file write
- ResultSrc_o  out  2  00 = ALUOut, 01 = ReadData reg, 10 = ALUResult
- ALUSrcA_o  out  2  00 = PC, 01 = OldPC, 10 = rs1 reg
- ALUSrcB_o  out  2  00 = rs2 reg, 01 = ImmExt, 10 = constant 4
- ImmSrc_o  out  3  000 = I, 001 = B, 010 = S, 011 = U, 100 = J; decoded from op_i in every state; unknown op gives 000
- ALUControl_o  out  3  000 add, 001 sub, 010 and, 011 or, 100 pass B, 101 slt, 110 sll
- instr_done_o  out  1  one-cycle pulse in the final state of each instruction
- trap_o  out  1  sticky illegal-opcode flag

## Operation
- Outputs are combinational decode of state, plus op/funct/Zero where noted. Any signal not listed for a state is 0; ALU defaults to add.
- Decode of op_i happens only in DECODE. The IR is stable from DECODE until the next FETCH completes.
- FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, add, ResultSrc=10, PCWrite=1. Next state: DECODE.
- DECODE: SrcA=01, SrcB=01, add (branch target into ALUOut). Next state by opcode:
  - load or store (0000011/0100011): MEMADR
  - 0110011: EXECR
  - 0010011: EXECI
  - 1100011: BRANCH
  - 1101111: JAL
  - 1100111: JALR
  - 0110111: LUI
  - anything else: TRAP
- MEMADR: SrcA=10, SrcB=01, add. Next: MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, done. Next: FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, done. Next: FETCH.
- EXECR: SrcA=10, SrcB=00, ALU from funct decode. Next: ALUWB.
- EXECI: SrcA=10, SrcB=01, ALU from funct decode. Next: ALUWB.
- LUI: SrcB=01, pass B. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, done. Next: FETCH.
- Funct decode:
  - funct3 000: sub only when funct7=1 and op[5]=1, else add
  - 001: sll; 010: slt; 110: or; 111: and
  - other funct3: add
- BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00, done. PCWrite = (funct3=000 & Zero) | (funct3=001 & !Zero); other funct3 never taken. Next: FETCH.
- JAL: SrcA=01, SrcB=01, add, ResultSrc=10, PCWrite=1. Next: LINKWB.
- JALR: SrcA=10, SrcB=01, add, ResultSrc=10, PCWrite=1. Next: LINKWB.
- LINKWB: SrcA=01, SrcB=10, add, ResultSrc=10, RegWrite=1, done. Next: FETCH.
- TRAP: all enables 0, trap_o=1. Exit only via rst.

## Timing
- Cycles per instruction, FETCH to last state inclusive:
  - branch: 3
  - R, I, LUI, store, JAL, JALR: 4
  - load: 5
- Reset: state forced to FETCH asynchronously. trap_o clears to 0. Outputs immediately show FETCH decode (PCWrite=IRWrite=1, all others 0 except SrcB=10, ResultSrc=10). The datapath registers are reset in parallel.
- Reset mid-instruction abandons the instruction. No partial RegWrite or MemWrite occurs after rst rises.
- instr_done_o is never asserted in FETCH, DECODE or TRAP.

## Configuration
- BUS_WAIT_EN defined: the mem_ready_i port exists. FETCH, MEMREAD and MEMWRITE hold while mem_ready_i=0.
  - In held FETCH: PCWrite and IRWrite = mem_ready_i.
  - In held MEMWRITE: MemWrite stays 1; instr_done_o = mem_ready_i.
  - Each stalled cycle adds exactly one cycle to latency.
- BUS_WAIT_EN undefined: no port; every memory state lasts one cycle.

## Structure
- Package ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALUControl constants
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings
- One sub-module, alu_decoder: combinational mapping of (ALUOp, funct3, funct7, op[5]) to ALUControl, instanced inside this block.
- State register and next-state logic live in multicycle_controller.

## Test plan
- add x3,x1,x2 (0x002081B3) after reset -> states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4, ALUControl=000 in EXECR, instr_done_o pulse in cycle 4.
- lw (op 0000011) then sw (op 0100011) -> load takes 5 cycles with ResultSrc=01 at writeback; store takes 4 cycles with MemWrite=1 and AdrSrc=1 only in cycle 4.
- beq with Zero_i=1, then bne with Zero_i=1 -> PCWrite=1 in BRANCH for the first, PCWrite=0 for the second; both 3 cycles.
- jalr (op 1100111) -> JALR state with PCWrite=1 and SrcA=10; LINKWB with RegWrite=1, SrcA=01, SrcB=10.
- op 1111111 -> TRAP, trap_o=1, no enables for 20 cycles; assert rst -> FETCH and trap_o=0.
- BUS_WAIT_EN with mem_ready_i low for 3 cycles in FETCH -> PCWrite and IRWrite stay 0 for 3 cycles then pulse once; add completes in 7 cycles.
